// File: rtl/keypad_entry_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keypad_entry_controller
// Purpose  : Debounces 10 keypad lines, resolves highest key to a BCD digit,
//            offers it on valid/ready and shifts it into an entry register.
//            Optional held-key autorepeat: define KEYPAD_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_entry_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NUM_DIGITS      = 4,
    parameter int REPEAT_CYCLES   = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [9:0]                          D_in,
    input  logic                                digit_ready,
    input  logic                                clear,
    output logic [3:0]                          BCD_out,
    output logic                                digit_valid,
    output logic [4*NUM_DIGITS-1:0]             entry,
    output logic [$clog2(NUM_DIGITS+1)-1:0]     entry_count,
    output logic                                overrun,
    output logic                                busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int EC_W  = $clog2(NUM_DIGITS + 1);
    localparam int EW    = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] C_DEB_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [EC_W-1:0]  C_EC_MAX   = EC_W'(NUM_DIGITS);

    if (DEBOUNCE_CYCLES < 2 || NUM_DIGITS < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("keypad_entry_controller: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_DEB = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_DEB   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         sync1_q, ks_q;
    logic [9:0]         cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         bcd_q, bcd_d;
    logic               valid_q, valid_d;
    logic [EW-1:0]      entry_q, entry_d;
    logic [EC_W-1:0]    count_q, count_d;
    logic               overrun_q, overrun_d;
    logic               emit;
    logic               accept;
    logic [3:0]         digit;
    logic [EW-1:0]      entry_base;
    logic [EC_W-1:0]    count_base;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] C_RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0]   rpt_q, rpt_d;
`endif

    // Highest-numbered active key wins.
    function automatic logic [3:0] prio_digit(input logic [9:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    assign digit = prio_digit(cand_q);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_d   = rpt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ks_q != 10'd0) begin
                    cand_d  = ks_q;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_PRESS_DEB;
                end
            end
            ST_PRESS_DEB: begin
                if (ks_q == 10'd0) begin
                    state_d = ST_IDLE;
                end else if (ks_q == cand_q) begin
                    // cnt counts matching samples after capture; the capture
                    // sample plus DEBOUNCE_CYCLES matches are required.
                    if (cnt_q == C_DEB_DONE) begin
                        emit    = 1'b1;
                        state_d = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rpt_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cand_d = ks_q;
                    cnt_d  = CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (ks_q == 10'd0) begin
                    cnt_d   = CNT_W'(1);
                    state_d = ST_REL_DEB;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (rpt_q == C_RPT_LAST) begin
                    emit  = 1'b1;
                    rpt_d = '0;
                end else begin
                    rpt_d = rpt_q + RPT_W'(1);
                end
`endif
            end
            ST_REL_DEB: begin
                if (ks_q != 10'd0) begin
                    state_d = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rpt_d   = '0;
`endif
                end else if (cnt_q == C_DEB_DONE) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear is applied first so a same-cycle emit lands on an empty entry.
    always_comb begin
        accept     = !valid_q || digit_ready;
        entry_base = clear ? '0 : entry_q;
        count_base = clear ? '0 : count_q;
        bcd_d      = bcd_q;
        valid_d    = valid_q;
        entry_d    = entry_base;
        count_d    = count_base;
        overrun_d  = clear ? 1'b0 : overrun_q;
        if (emit && accept) begin
            bcd_d   = digit;
            valid_d = 1'b1;
            entry_d = (entry_base << 4) | EW'(digit);
            count_d = (count_base == C_EC_MAX) ? count_base : count_base + EC_W'(1);
        end else if (emit) begin
            overrun_d = 1'b1;
        end else if (valid_q && digit_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sync1_q   <= '0;
            ks_q      <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
            entry_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= D_in;
            ks_q      <= sync1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            entry_q   <= entry_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q     <= rpt_d;
`endif
        end
    end

    assign BCD_out     = bcd_q;
    assign digit_valid = valid_q;
    assign entry       = entry_q;
    assign entry_count = count_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire
